// File: rtl/pcpu_mem_sys_if.sv
// Core-side bus between the pcpu pipeline and its instruction/data memory subsystem.
// The core drives addresses and store data; the memory returns fetched and loaded words.
interface pcpu_mem_sys_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_dataout;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_datain;
    logic [DATA_W-1:0] d_dataout;

    modport master (
        output i_addr,
        output d_addr,
        output d_we,
        output d_datain,
        input  i_dataout,
        input  d_dataout
    );

    modport slave (
        input  i_addr,
        input  d_addr,
        input  d_we,
        input  d_datain,
        output i_dataout,
        output d_dataout
    );
endinterface

// File: rtl/pcpu_mem_sys.sv
// Instruction/data memory subsystem for pcpu: latency-configurable read pipelines,
// side-band preload, sticky HALT detection and an enabled-cycle counter.
module pcpu_mem_sys #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned I_LAT   = 1,
    parameter int unsigned D_LAT   = 1,
    parameter int unsigned WR_MODE = 0,
    parameter logic [4:0]  HALT_OP = 5'b00001,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    pcpu_mem_sys_if.slave     bus,
    input  logic              ld_we,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              halt_clr,
    output logic              halt_seen,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (I_LAT < 1 || I_LAT > 4) begin : g_bad_i_lat
        $error("pcpu_mem_sys: I_LAT must be in 1..4");
    end
    if (D_LAT < 1 || D_LAT > 4) begin : g_bad_d_lat
        $error("pcpu_mem_sys: D_LAT must be in 1..4");
    end

    logic [DATA_W-1:0] imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];
    logic [DATA_W-1:0] i_pipe_q [I_LAT];
    logic [DATA_W-1:0] d_pipe_q [D_LAT];
    logic [DATA_W-1:0] d_rd;
    logic [4:0]        i_op;

    // Preload is issued after the CPU write so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (enable && bus.d_we) begin
            dmem[bus.d_addr] <= bus.d_datain;
        end
        if (ld_we) begin
            if (ld_sel) begin
                dmem[ld_addr] <= ld_data;
            end else begin
                imem[ld_addr] <= ld_data;
            end
        end
    end

    // Array reads see the pre-edge contents, so WR_MODE=0 needs no special case.
    always_comb begin
        d_rd = dmem[bus.d_addr];
        if (WR_MODE == 1 && bus.d_we) begin
            d_rd = bus.d_datain;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < int'(I_LAT); s++) i_pipe_q[s] <= '0;
            for (int s = 0; s < int'(D_LAT); s++) d_pipe_q[s] <= '0;
        end else if (enable) begin
            i_pipe_q[0] <= imem[bus.i_addr];
            d_pipe_q[0] <= d_rd;
            for (int s = 1; s < int'(I_LAT); s++) i_pipe_q[s] <= i_pipe_q[s-1];
            for (int s = 1; s < int'(D_LAT); s++) d_pipe_q[s] <= d_pipe_q[s-1];
        end
    end

    assign bus.i_dataout = i_pipe_q[I_LAT-1];
    assign bus.d_dataout = d_pipe_q[D_LAT-1];
    assign i_op          = bus.i_dataout[DATA_W-1 -: 5];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt_seen   <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (halt_clr) begin
                halt_seen <= 1'b0;
            end else if (enable && i_op == HALT_OP) begin
                halt_seen <= 1'b1;
            end
            // Counts the HALT edge itself, then freezes; saturates instead of wrapping.
            if (enable && !halt_seen && cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pcpu_mem_sys.sv
// Randomised and directed bench for pcpu_mem_sys; two instances with different latencies,
// read-during-write modes and counter widths are checked against a history-based model.
module tb_pcpu_mem_sys;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int          NH = 8192;
    localparam logic [4:0]  HALT = 5'b00001;

    logic          clock = 1'b0;
    logic          reset, enable, ld_we, ld_sel, halt_clr, d_we;
    logic [AW-1:0] i_addr, d_addr, ld_addr;
    logic [DW-1:0] d_datain, ld_data;
    logic          halt0, halt1;
    logic [15:0]   cnt0;
    logic [3:0]    cnt1;
    int            n_checks = 0;
    int            n_errors = 0;

    pcpu_mem_sys_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    pcpu_mem_sys_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.i_addr = i_addr;
    assign bus0.d_addr = d_addr;
    assign bus0.d_we = d_we;
    assign bus0.d_datain = d_datain;
    assign bus1.i_addr = i_addr;
    assign bus1.d_addr = d_addr;
    assign bus1.d_we = d_we;
    assign bus1.d_datain = d_datain;

    pcpu_mem_sys #(
        .DATA_W(DW), .ADDR_W(AW), .I_LAT(1), .D_LAT(3), .WR_MODE(0),
        .HALT_OP(HALT), .CNT_W(16)
    ) u_dut0 (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus0),
        .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .halt_clr(halt_clr), .halt_seen(halt0), .cycle_count(cnt0)
    );

    pcpu_mem_sys #(
        .DATA_W(DW), .ADDR_W(AW), .I_LAT(2), .D_LAT(1), .WR_MODE(1),
        .HALT_OP(HALT), .CNT_W(4)
    ) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus1),
        .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .halt_clr(halt_clr), .halt_seen(halt1), .cycle_count(cnt1)
    );

    always #5 clock = ~clock;

    // Reference model: memory images plus the word read at each enabled edge since reset.
    logic [DW-1:0] m_imem [256];
    logic [DW-1:0] m_dmem [256];
    logic [DW-1:0] m_ri [NH];
    logic [DW-1:0] m_rd [2][NH];
    int            m_n;
    int            m_cnt [2];
    bit            m_halt [2];
    int            lat_i [2] = '{1, 2};
    int            lat_d [2] = '{3, 1};
    int            wrm [2]   = '{0, 1};
    int            cmax [2]  = '{65535, 15};

    function automatic logic [DW-1:0] exp_i(int u);
        int k;
        k = m_n - lat_i[u] + 1;
        return (k >= 1) ? m_ri[k] : '0;
    endfunction

    function automatic logic [DW-1:0] exp_d(int u);
        int k;
        k = m_n - lat_d[u] + 1;
        return (k >= 1) ? m_rd[u][k] : '0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] iw;
        for (int u = 0; u < 2; u++) begin
            if (enable) begin
                iw = exp_i(u);
                if (!m_halt[u] && m_cnt[u] < cmax[u]) m_cnt[u]++;
                if (halt_clr) m_halt[u] = 1'b0;
                else if (iw[DW-1 -: 5] == HALT) m_halt[u] = 1'b1;
            end else if (halt_clr) begin
                m_halt[u] = 1'b0;
            end
        end
        if (enable) begin
            if (m_n < NH - 1) m_n++;
            m_ri[m_n] = m_imem[i_addr];
            for (int u = 0; u < 2; u++) begin
                m_rd[u][m_n] = (wrm[u] == 1 && d_we) ? d_datain : m_dmem[d_addr];
            end
            if (d_we) m_dmem[d_addr] = d_datain;
        end
        if (ld_we) begin
            if (ld_sel) m_dmem[ld_addr] = ld_data;
            else m_imem[ld_addr] = ld_data;
        end
    endtask

    task automatic check_all();
        check_eq("i_data0", 32'(bus0.i_dataout), 32'(exp_i(0)));
        check_eq("i_data1", 32'(bus1.i_dataout), 32'(exp_i(1)));
        check_eq("d_data0", 32'(bus0.d_dataout), 32'(exp_d(0)));
        check_eq("d_data1", 32'(bus1.d_dataout), 32'(exp_d(1)));
        check_eq("halt0", 32'(halt0), 32'(m_halt[0]));
        check_eq("halt1", 32'(halt1), 32'(m_halt[1]));
        check_eq("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        check_eq("cnt1", 32'(cnt1), 32'(m_cnt[1]));
    endtask

    // Called at a falling edge; inputs change there and outputs are sampled there.
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic do_reset();
        enable = 1'b0;
        d_we = 1'b0;
        ld_we = 1'b0;
        halt_clr = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_i0", 32'(bus0.i_dataout), 32'h0);
        check_eq("rst_i1", 32'(bus1.i_dataout), 32'h0);
        check_eq("rst_d0", 32'(bus0.d_dataout), 32'h0);
        check_eq("rst_d1", 32'(bus1.d_dataout), 32'h0);
        check_eq("rst_halt0", 32'(halt0), 32'h0);
        check_eq("rst_halt1", 32'(halt1), 32'h0);
        check_eq("rst_cnt0", 32'(cnt0), 32'h0);
        check_eq("rst_cnt1", 32'(cnt1), 32'h0);
        m_n = 0;
        m_halt = '{1'b0, 1'b0};
        m_cnt = '{0, 0};
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic preload(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] w);
        enable = 1'b0;
        ld_we = 1'b1;
        ld_sel = sel;
        ld_addr = a;
        ld_data = w;
        step();
        ld_we = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w;
        reset = 1'b0;
        enable = 1'b0;
        ld_we = 1'b0;
        ld_sel = 1'b0;
        halt_clr = 1'b0;
        d_we = 1'b0;
        i_addr = '0;
        d_addr = '0;
        ld_addr = '0;
        d_datain = '0;
        ld_data = '0;
        @(negedge clock);
        do_reset();

        for (int a = 0; a < 256; a++) begin
            w = DW'($urandom);
            if (a == 0) w = 16'h0810;
            if (a == 1) w = 16'h1011;
            preload(1'b0, AW'(a), w);
        end
        for (int a = 0; a < 256; a++) begin
            w = DW'($urandom);
            if (a == 0) w = 16'h00AB;
            if (a == 2) w = 16'h1111;
            preload(1'b1, AW'(a), w);
        end

        // Fetch after preload
        enable = 1'b1;
        i_addr = 8'd0;
        d_addr = 8'd0;
        step();
        check_eq("fetch0", 32'(bus0.i_dataout), 32'h0810);
        i_addr = 8'd1;
        step();
        check_eq("fetch1", 32'(bus0.i_dataout), 32'h1011);

        // Three-cycle data latency
        do_reset();
        enable = 1'b1;
        d_addr = 8'd0;
        step();
        check_eq("dlat_k", 32'(bus0.d_dataout), 32'h0);
        d_addr = 8'd5;
        step();
        check_eq("dlat_k1", 32'(bus0.d_dataout), 32'h0);
        step();
        check_eq("dlat_k2", 32'(bus0.d_dataout), 32'h00AB);

        // Read during write to the same address
        d_addr = 8'd2;
        d_we = 1'b1;
        d_datain = 16'h3CAB;
        step();
        check_eq("rdw_new1", 32'(bus1.d_dataout), 32'h3CAB);
        d_we = 1'b0;
        step();
        check_eq("rdw_next1", 32'(bus1.d_dataout), 32'h3CAB);
        step();
        check_eq("rdw_old0", 32'(bus0.d_dataout), 32'h1111);
        step();
        check_eq("rdw_next0", 32'(bus0.d_dataout), 32'h3CAB);

        // Stall with a read in flight and CPU writes that must be ignored
        d_addr = 8'd7;
        step();
        enable = 1'b0;
        d_we = 1'b1;
        d_datain = 16'hFFFF;
        repeat (3) step();
        enable = 1'b1;
        d_we = 1'b0;
        repeat (3) step();
        check_eq("stall_rd", 32'(bus0.d_dataout), 32'(m_dmem[7]));

        // Four NOPs then HALT
        for (int a = 0; a < 4; a++) preload(1'b0, AW'(a), 16'h0000);
        preload(1'b0, 8'd4, 16'h0800);
        do_reset();
        enable = 1'b1;
        for (int s = 0; s < 8; s++) begin
            i_addr = (s < 4) ? AW'(s) : 8'd4;
            step();
            if (s == 4) check_eq("halt_pre", 32'(halt0), 32'h0);
            if (s == 5) begin
                check_eq("halt_set", 32'(halt0), 32'h1);
                check_eq("halt_cnt", 32'(cnt0), 32'd6);
            end
        end
        check_eq("halt_hold", 32'(cnt0), 32'd6);
        halt_clr = 1'b1;
        i_addr = 8'd0;
        step();
        halt_clr = 1'b0;
        check_eq("clr_wins", 32'(halt0), 32'h0);
        check_eq("clr_cnt", 32'(cnt0), 32'd6);
        step();
        check_eq("cnt_resume", 32'(cnt0), 32'd7);

        // Counter saturation on the narrow instance
        do_reset();
        enable = 1'b1;
        i_addr = 8'd0;
        repeat (20) step();
        check_eq("sat1", 32'(cnt1), 32'd15);
        check_eq("nosat0", 32'(cnt0), 32'd20);

        // Random traffic with an asynchronous reset in the middle
        for (int s = 0; s < 400; s++) begin
            if (s == 200) do_reset();
            enable = ($urandom_range(3) != 0);
            i_addr = AW'($urandom);
            d_addr = AW'($urandom);
            d_we = ($urandom_range(2) == 0);
            d_datain = DW'($urandom);
            ld_we = ($urandom_range(9) == 0);
            ld_sel = 1'($urandom);
            ld_addr = AW'($urandom);
            ld_data = DW'($urandom);
            halt_clr = enable && ($urandom_range(7) == 0);
            step();
        end

        // Reset with reads pending, then read back both memories
        d_we = 1'b0;
        ld_we = 1'b0;
        enable = 1'b1;
        d_addr = 8'd9;
        step();
        do_reset();
        enable = 1'b1;
        for (int a = 0; a < 24; a++) begin
            i_addr = AW'(a);
            d_addr = AW'(a);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
